const_seq: RTL and testbench
============================

// Module: const_seq
// PURPOSE
//  Parametrised constant-pattern sequencer: a small table of IW-bit literals, each tagged with a width-conversion mode,
//  is played out one entry per handshake as W-bit words. Provides the zero/sign-extend, wrap (mod 2^W) and
//  saturating literal-fit behaviours as selectable runtime modes. Feeds lab datapaths and test stimulus stages.
// PARAMETERS
//  W      8   output word width (>=2)
//  IW     16  stored literal width (>=2; IW<W and IW>=W both legal)
//  DEPTH  8   table entries (power of 2, >=2); AW = $clog2(DEPTH)
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous reset, active-high
//  wr_en    in   1      table write strobe
//  wr_addr  in   AW     table write index
//  wr_data  in   IW     literal to store
//  wr_mode  in   2      conversion mode: 0 WRAP, 1 SEXT, 2 USAT, 3 SSAT
//  start    in   1      begin playback (accepted in IDLE only)
//  len      in   AW+1   entries to play, 1..DEPTH; sampled at start
//  loop     in   1      1: restart at entry 0 after last; sampled at start
//  o_valid  out  1      o_data/o_idx/o_clip valid
//  o_ready  in   1      consumer accepts when o_valid & o_ready
//  o_data   out  W      converted word
//  o_idx    out  AW     table index of o_data
//  o_clip   out  1      saturation clamped this word (USAT/SSAT only)
//  busy     out  1      FSM in RUN
//  done     out  1      one-cycle pulse on non-loop playback completion
// BEHAVIOUR
//  - Reset (async, any time incl. mid-run): table all {0,WRAP}; state IDLE; all outputs 0.
//  - Conversion of literal x (IW bits) to W bits:
//    WRAP: IW>=W -> x[W-1:0]; IW<W -> zero-extend. SEXT: IW>=W -> x[W-1:0]; IW<W -> sign-extend.
//    USAT: x unsigned; x>2^W-1 -> 2^W-1, o_clip=1; else zero-extended/truncated value, o_clip=0.
//    SSAT: x signed; x>2^(W-1)-1 -> 2^(W-1)-1; x<-2^(W-1) -> -2^(W-1); o_clip=1 on clamp.
//    WRAP/SEXT never set o_clip. If IW<=W saturation can never clamp.
//  - FSM IDLE -> RUN on start & len!=0 (start with len==0 ignored, stays IDLE, no done).
//    Latency: start sampled at edge t -> o_valid=1 with entry 0 from cycle t+1.
//  - RUN: o_data/o_idx/o_clip registered; held stable while o_valid & !o_ready. On handshake at idx<len-1:
//    next cycle presents idx+1 (no bubble). At idx==len-1: loop=1 -> idx 0, stay RUN; loop=0 -> DONE.
//  - DONE: o_valid=0, done=1 for exactly one cycle, then IDLE. Looping playback never ends (reset only).
//  - busy=1 exactly in RUN. start during RUN/DONE ignored; len/loop changes after start ignored.
//  - Writes allowed in any state, 1-cycle commit. A write to the entry currently presented does not change held
//    o_data; a write to a later entry is seen when that entry is fetched. Same-cycle write+fetch of the
//    same index fetches the old contents.
// STRUCTURE
//  - const_pkg: mode encodings (MODE_WRAP/SEXT/USAT/SSAT), FSM state typedef (IDLE/RUN/DONE).
//  - Sub-module width_conv (combinational, params W/IW): {x, mode} -> {y, clip}; instanced once before output reg.
//  - Top: table regs, index counter, FSM, output register.
// TESTING (W=8, IW=16, DEPTH=8)
//  - Conversion: entries {0:16'h0159 WRAP, 1:16'hFFFB SEXT, 2:16'h0159 SSAT, 3:16'hFFFB USAT, 4:16'hFF00 SSAT},
//    len=5, o_ready=1 -> o_data 59,FB,7F,FF,80; o_clip 0,0,1,1,1; o_idx 0..4; done pulse 1 cycle after 5th beat.
//  - Latency/throughput: start at cycle 0, o_ready=1 -> o_valid at cycle 1, one word per cycle, busy 1..5.
//  - Backpressure: o_ready=0 for 4 cycles on entry 2 -> o_data=7F,o_idx=2 held stable; resumes with entry 3.
//  - Loop: len=2, loop=1 -> idx sequence 0,1,0,1,... with no done; start pulses during RUN ignored.
//  - Write during run: rewrite entry 1 to 16'h0005 WRAP while entry 0 presented -> entry 1 emits 8'h05;
//    rewrite entry 0 while presented -> held value unchanged.
//  - Reset mid-run: rst asserted between edges mid-entry 3 -> o_valid,busy,o_data drop to 0 immediately; table
//    reads back 0; start with len=1 then emits 8'h00.
//  - len=0 start -> no o_valid, no done, busy stays 0.

Source files
------------

// File: rtl/const_pkg.sv
// Shared encodings for the constant-pattern sequencer: literal conversion modes and playback FSM states.
package const_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SEXT = 2'd1,
    MODE_USAT = 2'd2,
    MODE_SSAT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/width_conv.sv
// Combinational IW-bit literal to W-bit word conversion with wrap, sign-extend and saturating modes.
module width_conv
  import const_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = 16
) (
  input  logic [IW-1:0] x,
  input  logic [1:0]    mode,
  output logic [W-1:0]  y,
  output logic          clip
);

  logic signed [IW-1:0] x_s;
  logic [W-1:0]         xz;
  logic [W-1:0]         xs;
  logic                 uovf;
  logic                 sovf;
  logic                 neg;

  assign x_s = $signed(x);
  assign neg = (x_s < 0);

  // Overflow only exists when the literal is wider than the word.
  generate
    if (IW > W) begin : g_narrow
      assign xz   = x[W-1:0];
      assign xs   = x[W-1:0];
      assign uovf = |x[IW-1:W];
      assign sovf = !((&x[IW-1:W-1]) || !(|x[IW-1:W-1]));
    end else if (IW == W) begin : g_equal
      assign xz   = x;
      assign xs   = x;
      assign uovf = 1'b0;
      assign sovf = 1'b0;
    end else begin : g_wide
      assign xz   = {{(W-IW){1'b0}}, x};
      assign xs   = {{(W-IW){x[IW-1]}}, x};
      assign uovf = 1'b0;
      assign sovf = 1'b0;
    end
  endgenerate

  function automatic logic [W-1:0] sat_u(input logic ovf, input logic [W-1:0] v);
    return ovf ? {W{1'b1}} : v;
  endfunction

  function automatic logic [W-1:0] sat_s(input logic ovf, input logic is_neg, input logic [W-1:0] v);
    if (!ovf)
      return v;
    return is_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    y    = xz;
    clip = 1'b0;
    case (mode_e'(mode))
      MODE_WRAP: y = xz;
      MODE_SEXT: y = xs;
      MODE_USAT: begin
        y    = sat_u(uovf, xz);
        clip = uovf;
      end
      MODE_SSAT: begin
        y    = sat_s(sovf, neg, xs);
        clip = sovf;
      end
      default: begin
        y    = xz;
        clip = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/const_seq.sv
// Constant-pattern sequencer: plays a writable table of tagged literals out as converted W-bit words
// over a valid/ready handshake, once or looping.
module const_seq
  import const_pkg::*;
#(
  parameter int W     = 8,
  parameter int IW    = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [1:0]    wr_mode,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          loop,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [W-1:0]  o_data,
  output logic [AW-1:0] o_idx,
  output logic          o_clip,
  output logic          busy,
  output logic          done
);

  logic [IW-1:0] tbl_data [DEPTH];
  logic [1:0]    tbl_mode [DEPTH];

  state_e        state;
  logic [AW:0]   len_q;
  logic          loop_q;
  logic          last;
  logic [AW-1:0] fetch_idx;
  logic [W-1:0]  conv_y;
  logic          conv_clip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_data[i] <= '0;
        tbl_mode[i] <= MODE_WRAP;
      end
    end else if (wr_en) begin
      tbl_data[wr_addr] <= wr_data;
      tbl_mode[wr_addr] <= wr_mode;
    end
  end

  // Fetch reads the table before this edge's write lands, so a same-index write+fetch sees old contents.
  assign last      = ({1'b0, o_idx} == (len_q - (AW+1)'(1)));
  assign fetch_idx = (state == RUN && !last) ? (o_idx + AW'(1)) : '0;

  width_conv #(
    .W  (W),
    .IW (IW)
  ) u_conv (
    .x    (tbl_data[fetch_idx]),
    .mode (tbl_mode[fetch_idx]),
    .y    (conv_y),
    .clip (conv_clip)
  );

  // Output stage: registered word, index and clip flag plus FSM flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      loop_q  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
      o_clip  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && len != '0) begin
            state   <= RUN;
            len_q   <= len;
            loop_q  <= loop;
            busy    <= 1'b1;
            o_valid <= 1'b1;
            o_data  <= conv_y;
            o_idx   <= fetch_idx;
            o_clip  <= conv_clip;
          end
        end
        RUN: begin
          if (o_ready) begin
            if (last && !loop_q) begin
              state   <= DONE;
              busy    <= 1'b0;
              o_valid <= 1'b0;
              done    <= 1'b1;
            end else begin
              o_data <= conv_y;
              o_idx  <= fetch_idx;
              o_clip <= conv_clip;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          o_valid <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_seq.sv
// Self-checking bench for const_seq: fixed conversion vectors, handshake corner sequences and
// randomized playback against a behavioural table model.
module tb_const_seq;
  localparam int W = 8, IW = 16, DEPTH = 8, AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic [1:0]    wr_mode;
  logic          start;
  logic [AW:0]   len;
  logic          loop;
  logic          o_valid;
  logic          o_ready;
  logic [W-1:0]  o_data;
  logic [AW-1:0] o_idx;
  logic          o_clip;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] mdl_d [DEPTH];
  logic [1:0]    mdl_m [DEPTH];

  typedef struct {
    logic [IW-1:0] d;
    logic [1:0]    m;
    logic [W-1:0]  y;
    logic          c;
  } vec_t;
  vec_t tv [5];

  const_seq #(.W(W), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mode(wr_mode), .start(start), .len(len), .loop(loop), .o_valid(o_valid),
    .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx), .o_clip(o_clip),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion from plain integer arithmetic on the literal's value.
  task automatic ref_conv(input logic [IW-1:0] x, input logic [1:0] m,
                          output logic [W-1:0] y, output logic c);
    int u;
    int s;
    u = int'(x);
    s = int'($signed(x));
    c = 1'b0;
    case (m)
      2'd0, 2'd1: y = W'(u % 256);
      2'd2: begin
        if (u > 255) begin y = 8'hFF; c = 1'b1; end
        else y = W'(u);
      end
      default: begin
        if (s > 127) begin y = 8'h7F; c = 1'b1; end
        else if (s < -128) begin y = 8'h80; c = 1'b1; end
        else y = W'(s & 255);
      end
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_d[i] = '0;
      mdl_m[i] = 2'd0;
    end
  endtask

  task automatic wr(input int a, input logic [IW-1:0] d, input logic [1:0] m);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_mode = m;
    @(negedge clk);
    wr_en = 1'b0;
    mdl_d[a] = d;
    mdl_m[a] = m;
  endtask

  task automatic check_beat(input int k);
    logic [W-1:0] y;
    logic c;
    ref_conv(mdl_d[k], mdl_m[k], y, c);
    chk("beat_valid", o_valid, 1);
    chk("beat_data", o_data, y);
    chk("beat_idx", o_idx, k);
    chk("beat_clip", o_clip, c);
    chk("beat_busy", busy, 1);
  endtask

  task automatic check_fixed(input int i);
    chk("vec_valid", o_valid, 1);
    chk("vec_data", o_data, tv[i].y);
    chk("vec_idx", o_idx, i);
    chk("vec_clip", o_clip, tv[i].c);
    chk("vec_busy", busy, 1);
  endtask

  task automatic load_vectors();
    for (int i = 0; i < 5; i++) wr(i, tv[i].d, tv[i].m);
  endtask

  task automatic random_run(input int L);
    int k;
    int cyc;
    loop = 1'b0; len = (AW+1)'(L); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < L) begin
      if (cyc > 200) begin
        chk("rand_timeout", 1, 0);
        break;
      end
      check_beat(k);
      o_ready = ($urandom_range(0, 3) != 0);
      if (o_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk("rand_done", done, 1);
    chk("rand_valid_off", o_valid, 0);
    @(negedge clk);
    chk("rand_done_off", done, 0);
    chk("rand_busy_off", busy, 0);
  endtask

  initial begin
    tv[0] = '{16'h0159, 2'd0, 8'h59, 1'b0};
    tv[1] = '{16'hFFFB, 2'd1, 8'hFB, 1'b0};
    tv[2] = '{16'h0159, 2'd3, 8'h7F, 1'b1};
    tv[3] = '{16'hFFFB, 2'd2, 8'hFF, 1'b1};
    tv[4] = '{16'hFF00, 2'd3, 8'h80, 1'b1};

    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_mode = '0;
    start = 0; len = '0; loop = 0; o_ready = 0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", o_data, 0);
    chk("rst_clip", o_clip, 0);
    rst = 1'b0;
    @(negedge clk);

    // Conversion vectors, latency and throughput.
    load_vectors();
    o_ready = 1'b1; len = 4'd5; loop = 1'b0; start = 1'b1;
    chk("lat_pre_valid", o_valid, 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_fixed(i);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("done_valid", o_valid, 0);
    chk("done_busy", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Backpressure on entry 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_fixed(i);
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      chk("bp_hold_data", o_data, 8'h7F);
      chk("bp_hold_idx", o_idx, 2);
      chk("bp_hold_valid", o_valid, 1);
      o_ready = 1'b0;
      @(negedge clk);
    end
    chk("bp_last_hold", o_data, 8'h7F);
    o_ready = 1'b1;
    @(negedge clk);
    check_fixed(3);
    @(negedge clk);
    check_fixed(4);
    @(negedge clk);
    chk("bp_done", done, 1);
    @(negedge clk);

    // Looping playback ignores start pulses and never signals done.
    len = 4'd2; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 4'd5; loop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("loop_idx", o_idx, i % 2);
      chk("loop_data", o_data, tv[i % 2].y);
      chk("loop_done", done, 0);
      chk("loop_busy", busy, 1);
      start = (i == 3 || i == 6);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("loop_rst_busy", busy, 0);
    rst = 1'b0;
    clear_model();
    @(negedge clk);

    // Table writes while playing, then asynchronous reset mid-entry 3.
    load_vectors();
    o_ready = 1'b0; len = 4'd5; loop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wr_e0_data", o_data, 8'h59);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0005; wr_mode = 2'd0;
    @(negedge clk);
    wr_addr = 3'd0; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_held_data", o_data, 8'h59);
    chk("wr_held_idx", o_idx, 0);
    o_ready = 1'b1;
    @(negedge clk);
    chk("wr_later_data", o_data, 8'h05);
    chk("wr_later_idx", o_idx, 1);
    @(negedge clk);
    check_fixed(2);
    @(negedge clk);
    check_fixed(3);
    o_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", o_data, 0);
    chk("arst_clip", o_clip, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    o_ready = 1'b1; len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_data", o_data, 8'h00);
    @(negedge clk);
    chk("post_rst_done", done, 1);
    @(negedge clk);

    // Zero length start is ignored.
    len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_valid", o_valid, 0);
      chk("len0_done", done, 0);
      chk("len0_busy", busy, 0);
      @(negedge clk);
    end

    // Randomized tables, lengths and backpressure.
    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [IW-1:0] d;
        case ($urandom_range(0, 3))
          0: d = IW'($urandom_range(0, 255));
          1: d = IW'(16'hFF80 + $urandom_range(0, 127));
          default: d = IW'($urandom);
        endcase
        wr(a, d, 2'($urandom_range(0, 3)));
      end
      random_run($urandom_range(1, DEPTH));
      o_ready = 1'b1;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
